led_word_serializer: RTL
========================

Name: led_word_serializer

Overview:
- Parametrised successor to the board-level single-LED bit blinker used to read arithmetic results off the iCE40.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits a framed serial pattern on one LED: a sync marker, then WIDTH bit slots LSB first, then an inter-frame gap.
- Sits between a datapath under test (e.g. the UPE multipliers) and a board LED pin, clocked from the 10 kHz low-frequency oscillator.

Parameters:
- WIDTH, 64, bits per frame (1..64).
- BIT_TICKS, 1250, clock cycles per bit slot (>=1).
- SYNC_TICKS, 2500, clock cycles of LED-high sync marker (>=1).
- GAP_TICKS, 2500, clock cycles of LED-low gap after the last bit (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a word.
- load_data  in  WIDTH  word to display.
- led  out  1  serial LED drive, registered.
- busy  out  1  frame in progress (state != IDLE).
- bit_index  out  7  index of the bit currently shown; 0 outside SHIFT.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: led=0, load_ready=1, busy=0, bit_index=0, frame_done=0, state=IDLE, tick counter=0, held word=0.
- Reset mid-frame aborts the frame; the next cycle is IDLE with LED low.
- States: IDLE, SYNC, SHIFT, GAP.
- Single tick counter, width $clog2 of the max tick parameter + 1; reloaded to 0 on every state or bit change.
- IDLE:
  - load_ready=1, led=0.
  - Handshake completes when load_valid && load_ready in cycle N. load_data is latched into a held register, and state is SYNC from N+1.
  - load_valid while not ready is ignored; the data is never captured late.
- SYNC: led=1 for exactly SYNC_TICKS cycles (N+1 .. N+SYNC_TICKS), then SHIFT.
- SHIFT:
  - led = held[bit_index] for exactly BIT_TICKS cycles per bit. Bit 0 is shown first; bit_index increments 0..WIDTH-1.
  - After BIT_TICKS cycles of bit WIDTH-1, go to GAP. No wrap of bit_index inside a frame.
- GAP: led=0 for exactly GAP_TICKS cycles.
- End of frame:
  - frame_done is high for exactly one cycle: the first cycle after GAP ends.
  - In that cycle the state is IDLE, and load_ready=1 in the same cycle.
- Frame length: SYNC_TICKS + WIDTH*BIT_TICKS + GAP_TICKS cycles of busy=1.
- load_ready=0 whenever busy=1.
- Back-to-back: a handshake in the frame_done cycle starts SYNC on the next cycle; no idle cycle is required.
- led and all outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LEDSER_REPEAT_EN.
- Defined:
  - On GAP completion the FSM re-enters SYNC directly and replays the held word indefinitely.
  - frame_done still pulses once per frame (first SYNC cycle of the next frame).
  - load_ready=1 only in the last GAP cycle. A handshake there replaces the held word for the next frame; otherwise the old word repeats.
  - IDLE is left on the first handshake and only re-entered by rst.
- Not defined: single-shot behaviour as specified above.

Test Plan:
- Basic frame:
  - Setup: WIDTH=8, BIT_TICKS=4, SYNC_TICKS=3, GAP_TICKS=2; rst then load 8'hA5 in cycle N.
  - Expect: led=1 at N+1..N+3; bit slots 1,0,1,0,0,1,0,1 of 4 cycles each from N+4; led=0 at N+36..N+37; frame_done=1 only at N+38; busy=1 for 37 cycles.
- Ignored load while busy: assert load_valid with 8'hFF during SHIFT -> load_ready=0, serial pattern unchanged, no second frame after frame_done.
- Back-to-back: hold load_valid with 8'h01 then 8'h80 -> second SYNC begins the cycle after frame_done; no IDLE gap; bit 7 high only in the last slot of frame 2.
- Reset mid-frame: rst asserted during bit 3 of 8'hA5 -> next cycle led=0, busy=0, load_ready=1, bit_index=0, frame_done never pulses.
- Full width:
  - Setup: WIDTH=64, BIT_TICKS=1, SYNC_TICKS=1, GAP_TICKS=1, load 64'h000000007F7DF7D7.
  - Expect: led sequence after sync matches bits 0..63 (first bits 1,1,1,0,1,0,1,1); total busy=66 cycles.
- LEDSER_REPEAT_EN: load 8'h3C, no further valid -> frames repeat identically with frame_done every 37 cycles; load 8'hC3 in the final GAP cycle -> next frame shows 8'hC3.

Source files
------------

// File: rtl/led_word_serializer.sv
// Frames a WIDTH-bit word onto one LED: high sync, LSB-first bit slots, low gap.
// Define LEDSER_REPEAT_EN to replay the held word continuously after the first load.
module led_word_serializer #(
    parameter int WIDTH      = 64,
    parameter int BIT_TICKS  = 1250,
    parameter int SYNC_TICKS = 2500,
    parameter int GAP_TICKS  = 2500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             led,
    output logic             busy,
    output logic [6:0]       bit_index,
    output logic             frame_done
);

    localparam int MAXT_A = (SYNC_TICKS > BIT_TICKS) ? SYNC_TICKS : BIT_TICKS;
    localparam int MAXT   = (GAP_TICKS > MAXT_A) ? GAP_TICKS : MAXT_A;
    localparam int CW     = $clog2(MAXT) + 1;

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_TICKS - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
    localparam logic [6:0]    IDX_LAST  = 7'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT,
        GAP
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [6:0]       bit_q, bit_n;
    logic [WIDTH-1:0] held_q, held_n;
    logic [WIDTH-1:0] sel_mask;
    logic             led_n;
    logic             fd_n;
    logic             take;
    logic             gap_end;

    assign gap_end = (state_q == GAP) && (cnt_q == GAP_LAST);

`ifdef LEDSER_REPEAT_EN
    assign load_ready = (state_q == IDLE) || gap_end;
`else
    assign load_ready = (state_q == IDLE);
`endif

    assign busy      = (state_q != IDLE);
    assign bit_index = (state_q == SHIFT) ? bit_q : 7'd0;
    assign take      = load_valid && load_ready;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q + CW'(1);
        bit_n    = bit_q;
        held_n   = held_q;
        fd_n     = 1'b0;
        led_n    = 1'b0;
        sel_mask = '0;

        if (take) begin
            held_n = load_data;
        end

        unique case (state_q)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (take) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_q == IDX_LAST) begin
                        state_n = GAP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_q + 7'd1;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    cnt_n = '0;
                    fd_n  = 1'b1;
`ifdef LEDSER_REPEAT_EN
                    state_n = SYNC;
`else
                    state_n = IDLE;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase

        // LED is registered, so it is decoded from the next-state values
        sel_mask = WIDTH'(1) << bit_n;
        unique case (1'b1)
            (state_n == SYNC):  led_n = 1'b1;
            (state_n == SHIFT): led_n = |(held_n & sel_mask);
            default:            led_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            held_q     <= '0;
            led        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            bit_q      <= bit_n;
            held_q     <= held_n;
            led        <= led_n;
            frame_done <= fd_n;
        end
    end

endmodule
